// File: rtl/core_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: funct3 encodings,
// FSM state type and operand signedness helpers.
package core_pkg;

  localparam logic [2:0] MD_OP_MUL    = 3'b000;
  localparam logic [2:0] MD_OP_MULH   = 3'b001;
  localparam logic [2:0] MD_OP_MULHSU = 3'b010;
  localparam logic [2:0] MD_OP_MULHU  = 3'b011;
  localparam logic [2:0] MD_OP_DIV    = 3'b100;
  localparam logic [2:0] MD_OP_DIVU   = 3'b101;
  localparam logic [2:0] MD_OP_REM    = 3'b110;
  localparam logic [2:0] MD_OP_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} md_state_t;

  function automatic logic is_signed_src1(input logic [2:0] op);
    return (op == MD_OP_MUL) || (op == MD_OP_MULH) || (op == MD_OP_MULHSU) ||
           (op == MD_OP_DIV) || (op == MD_OP_REM);
  endfunction

  // MULHSU takes rs2 as unsigned
  function automatic logic is_signed_src2(input logic [2:0] op);
    return (op == MD_OP_MUL) || (op == MD_OP_MULH) ||
           (op == MD_OP_DIV) || (op == MD_OP_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference when it does not borrow.
module ex_muldiv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            bit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);
  logic [XLEN:0] trial, diff;

  always_comb begin
    trial = {rem_i, bit_i};
    diff  = trial - {1'b0, divisor_i};
    q_o   = ~diff[XLEN];
    // rem_i < divisor keeps the restored remainder within XLEN bits
    rem_o = q_o ? diff[XLEN-1:0] : trial[XLEN-1:0];
  end
endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit on magnitudes with final sign fix-up.
// Divide-by-zero and signed overflow answer straight from the accept edge.
module ex_muldiv
  import core_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_UNROLL = 1,   // power of two, strictly less than XLEN
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             md_req_valid,
  output logic             md_req_ready,
  input  logic [2:0]       md_req_op,
  input  logic [XLEN-1:0]  md_req_src1,
  input  logic [XLEN-1:0]  md_req_src2,
  input  logic [TAG_W-1:0] md_req_tag,
  input  logic             md_flush,
  output logic             md_rsp_valid,
  input  logic             md_rsp_ready,
  output logic [XLEN-1:0]  md_rsp_result,
  output logic [TAG_W-1:0] md_rsp_tag,
  output logic             md_busy
);
  localparam int U     = MUL_UNROLL;
  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] N_MUL = CNT_W'(XLEN / MUL_UNROLL);
  localparam logic [CNT_W-1:0] N_DIV = CNT_W'(XLEN);
  localparam logic [XLEN-1:0]  MIN_S = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t          state_q, state_d;
  logic [2:0]         op_q;
  logic [TAG_W-1:0]   tag_q, rsp_tag_q;
  logic [XLEN-1:0]    x_q, result_q;
  logic               neg_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*XLEN-1:0]  acc_q;

  logic               accept, s1, s2, is_div, div0, ovf, early, neg_in;
  logic [XLEN-1:0]    mag1, mag2, early_res;

  assign accept = md_req_valid & md_req_ready;

  // Accept-edge operand conditioning and early-out detection
  always_comb begin
    is_div    = md_req_op[2];
    s1        = is_signed_src1(md_req_op) & md_req_src1[XLEN-1];
    s2        = is_signed_src2(md_req_op) & md_req_src2[XLEN-1];
    mag1      = s1 ? -md_req_src1 : md_req_src1;
    mag2      = s2 ? -md_req_src2 : md_req_src2;
    neg_in    = (is_div & md_req_op[1]) ? s1 : (s1 ^ s2);
    div0      = (md_req_src2 == '0);
    ovf       = ~md_req_op[0] & (md_req_src1 == MIN_S) & (md_req_src2 == '1);
    early     = is_div & (div0 | ovf);
    early_res = div0 ? (md_req_op[1] ? md_req_src1 : '1)
                     : (md_req_op[1] ? '0 : MIN_S);
  end

  // Multiply: acc = {partial hi, remaining multiplier}, right-shifted U bits per step
  logic [U-1:0]      m;
  logic [XLEN+U-1:0] mcand_ext, mult_ext, sum;
  logic [2*XLEN-1:0] mul_acc, div_acc, step_acc, mfull;
  logic [XLEN-1:0]   drem, dsel, dfin, final_res;
  logic              dq;

  ex_muldiv_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i     (acc_q[2*XLEN-1:XLEN]),
    .bit_i     (acc_q[XLEN-1]),
    .divisor_i (x_q),
    .rem_o     (drem),
    .q_o       (dq)
  );

  always_comb begin
    m         = acc_q[U-1:0];
    mcand_ext = {{U{1'b0}}, x_q};
    mult_ext  = {{XLEN{1'b0}}, m};
    sum       = {{U{1'b0}}, acc_q[2*XLEN-1:XLEN]} + mcand_ext * mult_ext;
    mul_acc   = {sum, acc_q[XLEN-1:U]};
    // Divide: acc = {remainder, dividend shifting out / quotient shifting in}
    div_acc   = {drem, acc_q[XLEN-2:0], dq};
    step_acc  = op_q[2] ? div_acc : mul_acc;
    mfull     = neg_q ? -step_acc : step_acc;
    dsel      = op_q[1] ? step_acc[2*XLEN-1:XLEN] : step_acc[XLEN-1:0];
    dfin      = neg_q ? -dsel : dsel;
    if (op_q[2])                final_res = dfin;
    else if (op_q == MD_OP_MUL) final_res = mfull[XLEN-1:0];
    else                        final_res = mfull[2*XLEN-1:XLEN];
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = early ? DONE : CALC;
      CALC:    if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    if (md_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (md_flush) state_d = IDLE;
  end

  // FSM: outputs
  always_comb begin
    md_req_ready = (state_q == IDLE) & ~md_flush;
    md_rsp_valid = (state_q == DONE);
    md_busy      = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      op_q      <= '0;
      tag_q     <= '0;
      x_q       <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      rsp_tag_q <= '0;
    end else if (accept) begin
      op_q  <= md_req_op;
      tag_q <= md_req_tag;
      neg_q <= neg_in;
      x_q   <= is_div ? mag2 : mag1;
      acc_q <= {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
      cnt_q <= is_div ? N_DIV : N_MUL;
      if (early) begin
        result_q  <= early_res;
        rsp_tag_q <= md_req_tag;
      end
    end else if (state_q == CALC && !md_flush) begin
      acc_q <= step_acc;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        result_q  <= final_res;
        rsp_tag_q <= tag_q;
      end
    end
  end

  assign md_rsp_result = result_q;
  assign md_rsp_tag    = rsp_tag_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: arithmetic results, latency, backpressure,
// flush and asynchronous reset, plus a MUL_UNROLL=8 instance for latency.
module tb_ex_muldiv;
  logic        clk = 1'b0;
  logic        rst_b;
  logic        req_valid, req_ready, flush, rsp_valid, rsp_ready, busy;
  logic [2:0]  req_op;
  logic [31:0] src1, src2, rsp_result;
  logic [4:0]  req_tag, rsp_tag;

  logic        b_valid, b_ready, b_rsp_valid, b_busy;
  logic [31:0] b_result;
  logic [4:0]  b_tag;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32), .MUL_UNROLL(1), .TAG_W(5)) dut (
    .clk(clk), .rst_b(rst_b),
    .md_req_valid(req_valid), .md_req_ready(req_ready), .md_req_op(req_op),
    .md_req_src1(src1), .md_req_src2(src2), .md_req_tag(req_tag),
    .md_flush(flush),
    .md_rsp_valid(rsp_valid), .md_rsp_ready(rsp_ready),
    .md_rsp_result(rsp_result), .md_rsp_tag(rsp_tag), .md_busy(busy)
  );

  ex_muldiv #(.XLEN(32), .MUL_UNROLL(8), .TAG_W(5)) dut8 (
    .clk(clk), .rst_b(rst_b),
    .md_req_valid(b_valid), .md_req_ready(b_ready), .md_req_op(3'b000),
    .md_req_src1(32'd7), .md_req_src2(32'hFFFF_FFFD), .md_req_tag(5'd3),
    .md_flush(1'b0),
    .md_rsp_valid(b_rsp_valid), .md_rsp_ready(1'b1),
    .md_rsp_result(b_result), .md_rsp_tag(b_tag), .md_busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] t);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; src1 = a; src2 = b; req_tag = t;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // lat = clock edges after the accept edge until rsp_valid is seen
  // (0 means valid in the very next cycle, i.e. the early-out path)
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] t,
                       input logic [31:0] exp, input int exp_lat);
    int lat;
    send(op, a, b, t);
    wait_rsp(lat);
    chk({name, "_res"}, rsp_result, exp);
    chk({name, "_tag"}, {27'd0, rsp_tag}, {27'd0, t});
    chk({name, "_lat"}, lat, exp_lat);
    ack();
  endtask

  initial begin
    int lat, seen;
    rst_b = 1'b0; req_valid = 1'b0; req_op = '0; src1 = '0; src2 = '0; req_tag = '0;
    flush = 1'b0; rsp_ready = 1'b0; b_valid = 1'b0;
    #12;
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_tag", {27'd0, rsp_tag}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); rst_b = 1'b1;
    chk("idle_ready", {31'd0, req_ready}, 32'd1);

    do_op("mul",    3'b000, 32'd7,         32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 32);
    do_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 32);
    do_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 32);
    do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 32);
    do_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFD, 32);
    do_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF, 32);
    do_op("divu",   3'b101, 32'd100,       32'd7,         5'd7,  32'd14,        32);
    do_op("remu",   3'b111, 32'd100,       32'd7,         5'd8,  32'd2,         32);
    do_op("div0",   3'b100, 32'h1234,      32'd0,         5'd9,  32'hFFFF_FFFF, 0);
    do_op("rem0",   3'b110, 32'h1234,      32'd0,         5'd10, 32'h1234,      0);
    do_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 0);
    do_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,         0);

    // MUL_UNROLL=8 instance: 4 steps
    @(negedge clk); b_valid = 1'b1;
    @(posedge clk); #1; b_valid = 1'b0;
    lat = 0;
    while (!b_rsp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("mul8_lat", lat, 32'd4);
    chk("mul8_res", b_result, 32'hFFFF_FFEB);

    // Backpressure: result held while rsp_ready is low
    send(3'b101, 32'd100, 32'd7, 5'd13);
    wait_rsp(lat);
    for (int i = 0; i < 5; i++) begin
      chk("hold_res", rsp_result, 32'd14);
      chk("hold_tag", {27'd0, rsp_tag}, 32'd13);
      chk("hold_reqrdy", {31'd0, req_ready}, 32'd0);
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      @(posedge clk); #1;
    end
    ack();
    chk("post_ack_busy", {31'd0, busy}, 32'd0);
    chk("post_ack_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = 3'b000; src1 = 32'd3; src2 = 32'd5; req_tag = 5'd14;
    @(posedge clk); #1; req_valid = 1'b0;
    chk("b2b_accept", {31'd0, busy}, 32'd1);
    wait_rsp(lat);
    chk("b2b_res", rsp_result, 32'd15);
    chk("b2b_lat", lat, 32'd32);
    ack();

    // Flush during CALC cycle 10
    send(3'b000, 32'd9, 32'd9, 5'd15);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_valid", {31'd0, rsp_valid}, 32'd0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (rsp_valid) seen++; end
    chk("flush_no_rsp", seen, 32'd0);

    // Asynchronous reset mid-CALC, result register held 15 beforehand
    send(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd16);
    repeat (5) @(posedge clk);
    #2 rst_b = 1'b0;
    #1;
    chk("arst_result", rsp_result, 32'd0);
    chk("arst_tag", {27'd0, rsp_tag}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk); rst_b = 1'b1;

    // Flush beats a request in IDLE
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; req_op = 3'b000; src1 = 32'd2; src2 = 32'd2; req_tag = 5'd17;
    #1 chk("flushreq_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("flushreq_busy", {31'd0, busy}, 32'd0);
    req_valid = 1'b0; flush = 1'b0;

    do_op("after", 3'b111, 32'd17, 32'd5, 5'd18, 32'd2, 32);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
